// File: rtl/life_pkg.sv
// Shared types and defaults for the Game-of-Life sweep controller.
package life_pkg;

  localparam int unsigned LIFE_CELLS  = 64;
  localparam int unsigned LIFE_ADDR_W = 7;
  localparam int unsigned LIFE_GEN_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOADX  = 3'd1,
    S_LOADY  = 3'd2,
    S_TOGGLE = 3'd3,
    S_CALC   = 3'd4,
    S_COMMIT = 3'd5,
    S_DRAW   = 3'd6,
    S_DONE   = 3'd7
  } life_state_t;

  // One-hot datapath strobes; at most one field is set in any cycle.
  typedef struct packed {
    logic ld_x;
    logic ld_y;
    logic update_single;
    logic update_temp;
    logic update_grid;
    logic drw;
  } life_strobe_t;

endpackage

// File: rtl/life_cell_counter.sv
// Sweep index counter shared by the CALC, COMMIT and DRAW phases.
module life_cell_counter
  import life_pkg::*;
#(
  parameter int unsigned CELLS  = LIFE_CELLS,
  parameter int unsigned ADDR_W = LIFE_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              last_q, last_d;

  // Next index: clear wins, otherwise step and wrap after the last cell.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_q ? '0 : cnt_q + ADDR_W'(1);
    end
    last_d = (cnt_d == ADDR_W'(CELLS - 1));
  end

  // Counter and last-cell flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = last_q;

endmodule

// File: rtl/life_sweep_ctrl.sv
// Game-of-Life sequencing FSM: turns requests into datapath strobes and
// sweeps xy_position across the grid for each generation phase.
// Optional feature macro: LIFE_AUTORUN_EN (run/tick start step sequences).
module life_sweep_ctrl
  import life_pkg::*;
#(
  parameter int unsigned CELLS  = LIFE_CELLS,
  parameter int unsigned ADDR_W = LIFE_ADDR_W,
  parameter int unsigned GEN_W  = LIFE_GEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_x_req,
  input  logic              ld_y_req,
  input  logic              toggle_req,
  input  logic              step_req,
  input  logic              draw_req,
  input  logic              run,
  input  logic              tick,
  output logic              ld_x,
  output logic              ld_y,
  output logic              update_single,
  output logic              update_temp,
  output logic              update_grid,
  output logic              drw,
  output logic [ADDR_W-1:0] xy_position,
  output logic              plot,
  output logic              busy,
  output logic [GEN_W-1:0]  gen_count
);

  life_state_t       state_q, state_d;
  life_strobe_t      strobe_q, strobe_d;
  logic              busy_q, busy_d;
  logic              plot_q;
  logic              from_calc_q, from_calc_d;
  logic [GEN_W-1:0]  gen_q, gen_d;
  logic              step_start_c;
  logic              sweep_d;
  logic              cnt_clr;
  logic              last_cell;
  logic [ADDR_W-1:0] cnt;

`ifdef LIFE_AUTORUN_EN
  assign step_start_c = step_req | (run & tick);
`else
  logic unused_autorun;
  assign unused_autorun = run ^ tick;
  assign step_start_c   = step_req;
`endif

  // Next-state, strobe decode and sweep/generation bookkeeping.
  always_comb begin
    state_d     = state_q;
    strobe_d    = '0;
    from_calc_d = from_calc_q;
    gen_d       = gen_q;

    case (state_q)
      S_IDLE: begin
        if (ld_x_req)          state_d = S_LOADX;
        else if (ld_y_req)     state_d = S_LOADY;
        else if (toggle_req)   state_d = S_TOGGLE;
        else if (step_start_c) state_d = S_CALC;
        else if (draw_req)     state_d = S_DRAW;
      end
      S_LOADX, S_LOADY: state_d = S_IDLE;
      S_TOGGLE:         state_d = S_DRAW;
      S_CALC:           if (last_cell) state_d = S_COMMIT;
      S_COMMIT:         if (last_cell) state_d = S_DRAW;
      S_DRAW:           if (last_cell) state_d = S_DONE;
      S_DONE:           state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase

    case (state_d)
      S_LOADX:  strobe_d.ld_x          = 1'b1;
      S_LOADY:  strobe_d.ld_y          = 1'b1;
      S_TOGGLE: strobe_d.update_single = 1'b1;
      S_CALC:   strobe_d.update_temp   = 1'b1;
      S_COMMIT: strobe_d.update_grid   = 1'b1;
      S_DRAW:   strobe_d.drw           = 1'b1;
      default:  strobe_d               = '0;
    endcase

    busy_d  = (state_d != S_IDLE);
    sweep_d = (state_d == S_CALC) || (state_d == S_COMMIT) || (state_d == S_DRAW);
    // Restart the index on every phase entry and hold it at 0 outside sweeps.
    cnt_clr = !sweep_d || (state_d != state_q);

    if (state_d == S_CALC)      from_calc_d = 1'b1;
    else if (state_d == S_IDLE) from_calc_d = 1'b0;

    if ((state_d == S_DONE) && from_calc_q) gen_d = gen_q + GEN_W'(1);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      strobe_q    <= '0;
      busy_q      <= 1'b0;
      plot_q      <= 1'b0;
      from_calc_q <= 1'b0;
      gen_q       <= '0;
    end else begin
      state_q     <= state_d;
      strobe_q    <= strobe_d;
      busy_q      <= busy_d;
      plot_q      <= strobe_q.drw;
      from_calc_q <= from_calc_d;
      gen_q       <= gen_d;
    end
  end

  life_cell_counter #(
    .CELLS  (CELLS),
    .ADDR_W (ADDR_W)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .en_i   (sweep_d),
    .cnt_o  (cnt),
    .last_o (last_cell)
  );

  assign ld_x          = strobe_q.ld_x;
  assign ld_y          = strobe_q.ld_y;
  assign update_single = strobe_q.update_single;
  assign update_temp   = strobe_q.update_temp;
  assign update_grid   = strobe_q.update_grid;
  assign drw           = strobe_q.drw;
  assign xy_position   = cnt;
  assign plot          = plot_q;
  assign busy          = busy_q;
  assign gen_count     = gen_q;

endmodule

// File: tb/tb_life_sweep_ctrl.sv
// Directed bench for life_sweep_ctrl with a per-cycle expected-output queue.
module tb_life_sweep_ctrl;

  localparam logic [5:0] S0  = 6'b000000;
  localparam logic [5:0] LDX = 6'b100000;
  localparam logic [5:0] LDY = 6'b010000;
  localparam logic [5:0] US  = 6'b001000;
  localparam logic [5:0] UT  = 6'b000100;
  localparam logic [5:0] UG  = 6'b000010;
  localparam logic [5:0] DRW = 6'b000001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ld_x_req = 1'b0, ld_y_req = 1'b0, toggle_req = 1'b0;
  logic step_req = 1'b0, draw_req = 1'b0, run = 1'b0, tick = 1'b0;
  logic ld_x, ld_y, update_single, update_temp, update_grid, drw, plot, busy;
  logic [6:0]  xy_position;
  logic [15:0] gen_count;

  int total = 0;
  int bad   = 0;
  logic [14:0] q[$];
  logic [15:0] gen_exp = 16'd0;

  always #5 clk = ~clk;

  life_sweep_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .ld_x_req      (ld_x_req),
    .ld_y_req      (ld_y_req),
    .toggle_req    (toggle_req),
    .step_req      (step_req),
    .draw_req      (draw_req),
    .run           (run),
    .tick          (tick),
    .ld_x          (ld_x),
    .ld_y          (ld_y),
    .update_single (update_single),
    .update_temp   (update_temp),
    .update_grid   (update_grid),
    .drw           (drw),
    .xy_position   (xy_position),
    .plot          (plot),
    .busy          (busy),
    .gen_count     (gen_count)
  );

  function automatic logic [14:0] mk(logic [5:0] s, logic p, logic b, logic [6:0] xy);
    return {s, p, b, xy};
  endfunction

  function automatic logic [14:0] obs_vec();
    return {ld_x, ld_y, update_single, update_temp, update_grid, drw, plot, busy, xy_position};
  endfunction

  task automatic push_sweep(input logic [5:0] s);
    for (int i = 0; i < 64; i++)
      q.push_back(mk(s, (s == DRW) && (i > 0), 1'b1, 7'(i)));
  endtask

  task automatic push_done();
    q.push_back(mk(S0, 1'b1, 1'b1, 7'd0));
  endtask

  task automatic push_idle();
    q.push_back(mk(S0, 1'b0, 1'b0, 7'd0));
  endtask

  task automatic check_vec(input string tag, input logic [14:0] exp_v);
    logic [14:0] o;
    o = obs_vec();
    total++;
    assert (o === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, exp_v);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic check_gen(input string tag);
    total++;
    assert (gen_count === gen_exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, gen_count, gen_exp);
    end
  endtask

  // Drain the queue one cycle at a time; optionally pulse step_req at cycle inj_at.
  task automatic run_check(input string tag, input int inj_at, output int busy_n);
    int n = 0;
    busy_n = 0;
    while (q.size() > 0) begin
      check_vec(tag, q.pop_front());
      if (busy === 1'b1) busy_n++;
      step_req = (n == inj_at);
      n++;
      @(negedge clk);
    end
    step_req = 1'b0;
  endtask

  // Request pulse sampled on the next rising edge; returns at the following negedge.
  task automatic pulse(input logic [4:0] sel);
    {ld_x_req, ld_y_req, toggle_req, step_req, draw_req} = sel;
    @(negedge clk);
    {ld_x_req, ld_y_req, toggle_req, step_req, draw_req} = 5'b0;
  endtask

  initial begin
    int bn;

    // Power-on reset state.
    @(negedge clk);
    @(negedge clk);
    check_vec("reset_state", mk(S0, 1'b0, 1'b0, 7'd0));
    check_gen("reset_gen");
    reset = 1'b0;
    @(negedge clk);

    // Full step sequence.
    pulse(5'b00010);
    push_sweep(UT); push_sweep(UG); push_sweep(DRW); push_done(); push_idle();
    run_check("step_seq", -1, bn);
    check_int("step_busy_cycles", bn, 193);
    gen_exp++;
    check_gen("step_gen");

    // Reset mid-CALC at xy_position=30.
    pulse(5'b00010);
    repeat (30) @(negedge clk);
    check_vec("mid_calc_xy30", mk(UT, 1'b0, 1'b1, 7'd30));
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    gen_exp = 16'd0;
    check_vec("reset_mid_calc", mk(S0, 1'b0, 1'b0, 7'd0));
    check_gen("reset_mid_calc_gen");

    // ld_x wins over step; no sweep follows.
    pulse(5'b10010);
    q.push_back(mk(LDX, 1'b0, 1'b1, 7'd0));
    repeat (4) push_idle();
    run_check("ldx_priority", -1, bn);
    check_int("ldx_busy_cycles", bn, 1);

    // ld_y wins over toggle, step and draw.
    pulse(5'b01111);
    q.push_back(mk(LDY, 1'b0, 1'b1, 7'd0));
    repeat (3) push_idle();
    run_check("ldy_priority", -1, bn);
    check_int("ldy_busy_cycles", bn, 1);

    // Toggle wins over step and draw: single update then redraw.
    pulse(5'b00111);
    q.push_back(mk(US, 1'b0, 1'b1, 7'd0));
    push_sweep(DRW); push_done(); push_idle();
    run_check("toggle_seq", -1, bn);
    check_int("toggle_busy_cycles", bn, 66);
    check_gen("toggle_gen");

    // Step wins over draw.
    pulse(5'b00011);
    push_sweep(UT); push_sweep(UG); push_sweep(DRW); push_done(); push_idle();
    run_check("step_over_draw", -1, bn);
    gen_exp++;
    check_gen("step_over_draw_gen");

    // Draw only.
    pulse(5'b00001);
    push_sweep(DRW); push_done(); push_idle();
    run_check("draw_seq", -1, bn);
    check_int("draw_busy_cycles", bn, 65);
    check_gen("draw_gen");

    // step_req mid-COMMIT is dropped; exactly one generation.
    pulse(5'b00010);
    push_sweep(UT); push_sweep(UG); push_sweep(DRW); push_done();
    repeat (4) push_idle();
    run_check("step_while_busy", 74, bn);
    check_int("step_while_busy_cycles", bn, 193);
    gen_exp++;
    check_gen("step_while_busy_gen");

    // Auto-run: five ticks 300 cycles apart with run=1, then ticks with run=0.
    run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (299) @(negedge clk);
    end
`ifdef LIFE_AUTORUN_EN
    gen_exp = gen_exp + 16'd5;
`endif
    check_gen("autorun_run1_gen");
    check_vec("autorun_run1_idle", mk(S0, 1'b0, 1'b0, 7'd0));
    run = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (299) @(negedge clk);
    end
    check_gen("autorun_run0_gen");
    check_vec("autorun_run0_idle", mk(S0, 1'b0, 1'b0, 7'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
